// File: rtl/des_pkg.sv
// rtl/des_pkg.sv - DES width constants, permutation/S-box tables, state enum and helpers
package des_pkg;

    localparam int BLOCK_W  = 64;
    localparam int SUBKEY_W = 48;
    localparam int NROUNDS  = 16;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Tables use DES bit numbering: entry n names the source bit (1 = MSB)
    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17, 9,  1,  59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7};

    localparam int FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41, 9,  49, 17, 57, 25};

    localparam int E_T [48] = '{
        32, 1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
        8,  9,  10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};

    localparam int P_T [32] = '{
        16, 7, 20, 21, 29, 12, 28, 17, 1,  15, 23, 26, 5,  18, 31, 10,
        2,  8, 24, 14, 32, 27, 3,  9,  19, 13, 30, 6,  22, 11, 4,  25};

    // Row-major: index = row*16 + column
    localparam logic [3:0] SBOX [8][64] = '{
        '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,  0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
          4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,  15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
        '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,  3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
          0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,  13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
        '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,  13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
          13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,  1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
        '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,  13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
          10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,  3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
        '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,  14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
          4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,  11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
        '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,  10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
          9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,  4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
        '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,  13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
          1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,  6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
        '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,  1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
          7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,  2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

    function automatic logic [1:64] ip_perm(input logic [1:64] x);
        logic [1:64] y;
        for (int i = 0; i < 64; i++) y[i+1] = x[IP_T[i]];
        return y;
    endfunction

    function automatic logic [1:64] fp_perm(input logic [1:64] x);
        logic [1:64] y;
        for (int i = 0; i < 64; i++) y[i+1] = x[FP_T[i]];
        return y;
    endfunction

    function automatic logic [1:48] e_expand(input logic [1:32] x);
        logic [1:48] y;
        for (int i = 0; i < 48; i++) y[i+1] = x[E_T[i]];
        return y;
    endfunction

    function automatic logic [1:32] p_perm(input logic [1:32] x);
        logic [1:32] y;
        for (int i = 0; i < 32; i++) y[i+1] = x[P_T[i]];
        return y;
    endfunction

    // Outer bits of each 6-bit group pick the row, inner four the column
    function automatic logic [1:32] sbox_sub(input logic [1:48] x);
        logic [1:32] y;
        logic [5:0]  six;
        for (int s = 0; s < 8; s++) begin
            six = x[6*s+1 +: 6];
            y[4*s+1 +: 4] = SBOX[s][{six[5], six[0], six[4:1]}];
        end
        return y;
    endfunction

endpackage

// File: rtl/des_encryption_unrolled_if.sv
// rtl/des_encryption_unrolled_if.sv - host/consumer bus of the DES core (block_count with DES_BLOCK_COUNT_EN)
interface des_encryption_unrolled_if;
    logic         start;
    logic         decrypt;
    logic [1:64]  message;
    logic [1:768] round_keys;
    logic         busy;
    logic         done;
    logic [1:64]  result;
`ifdef DES_BLOCK_COUNT_EN
    logic [15:0]  block_count;

    modport master (output start, decrypt, message, round_keys,
                    input  busy, done, result, block_count);
    modport slave  (input  start, decrypt, message, round_keys,
                    output busy, done, result, block_count);
`else
    modport master (output start, decrypt, message, round_keys,
                    input  busy, done, result);
    modport slave  (input  start, decrypt, message, round_keys,
                    output busy, done, result);
`endif
endinterface

// File: rtl/des_round.sv
// rtl/des_round.sv - one combinational DES Feistel round
module des_round
    import des_pkg::*;
(
    input  logic [1:32] i_l,
    input  logic [1:32] i_r,
    input  logic [1:48] i_k,
    output logic [1:32] o_l,
    output logic [1:32] o_r
);
    logic [1:48] w_x;
    logic [1:32] w_f;

    assign w_x = e_expand(i_r) ^ i_k;
    assign w_f = p_perm(sbox_sub(w_x));
    assign o_l = i_r;
    assign o_r = i_l ^ w_f;
endmodule

// File: rtl/des_encryption_unrolled.sv
// rtl/des_encryption_unrolled.sv - iterative DES core, UNROLL rounds per clock; DES_BLOCK_COUNT_EN adds block_count
module des_encryption_unrolled
    import des_pkg::*;
#(
    parameter int UNROLL = 4
)
(
    input  logic                       clk,
    input  logic                       rst,
    des_encryption_unrolled_if.slave   bus
);
    localparam int ITER  = NROUNDS / UNROLL;
    localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8 || UNROLL == 16)) begin : g_bad_unroll
        $error("des_encryption_unrolled: UNROLL must be 1, 2, 4, 8 or 16");
    end

    state_t           r_state;
    logic [1:32]      r_l;
    logic [1:32]      r_r;
    logic [1:768]     r_keys;
    logic             r_mode;
    logic [CNT_W-1:0] r_cnt;
    logic [1:64]      r_result;
    logic             r_done;
`ifdef DES_BLOCK_COUNT_EN
    logic [15:0]      r_block_count;
`endif

    logic [1:32]      w_l [0:UNROLL];
    logic [1:32]      w_r [0:UNROLL];
    logic [1:48]      w_k [0:UNROLL-1];
    logic [1:64]      w_ip;

    assign w_ip   = ip_perm(bus.message);
    assign w_l[0] = r_l;
    assign w_r[0] = r_r;

    // Pick K_j (encrypt) or K_(17-j) (decrypt) for each round of this iteration
    always_comb begin
        for (int u = 0; u < UNROLL; u++) begin
            w_k[u] = r_keys[SUBKEY_W * (r_mode ? (NROUNDS - 1 - (int'(r_cnt) * UNROLL + u))
                                               : (int'(r_cnt) * UNROLL + u)) + 1 +: SUBKEY_W];
        end
    end

    for (genvar g = 0; g < UNROLL; g++) begin : g_round
        des_round u_round (
            .i_l (w_l[g]),
            .i_r (w_r[g]),
            .i_k (w_k[g]),
            .o_l (w_l[g+1]),
            .o_r (w_r[g+1])
        );
    end

    // Control FSM plus datapath registers; cnt returns to 0 on completion so the mux never leaves K1..K16
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_l      <= '0;
            r_r      <= '0;
            r_keys   <= '0;
            r_mode   <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
`ifdef DES_BLOCK_COUNT_EN
            r_block_count <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        {r_l, r_r} <= w_ip;
                        r_keys     <= bus.round_keys;
                        r_mode     <= bus.decrypt;
                        r_cnt      <= '0;
                        r_state    <= RUN;
                    end
                end
                RUN: begin
                    r_l <= w_l[UNROLL];
                    r_r <= w_r[UNROLL];
                    if (r_cnt == CNT_W'(ITER - 1)) begin
                        r_result <= fp_perm({w_r[UNROLL], w_l[UNROLL]});
                        r_done   <= 1'b1;
                        r_cnt    <= '0;
                        r_state  <= DONE;
`ifdef DES_BLOCK_COUNT_EN
                        r_block_count <= r_block_count + 16'd1;
`endif
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy   = (r_state != IDLE);
    assign bus.done   = r_done;
    assign bus.result = r_result;
`ifdef DES_BLOCK_COUNT_EN
    assign bus.block_count = r_block_count;
`endif
endmodule
